// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and the circular priority pick used by the shared-FIFO arbiter
// and any other round-robin bus arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Widest requester vector the generic pick function handles.
   localparam int RR_MAX = 32;
   localparam int RR_IW  = 5;

   typedef struct packed {
      logic             found;
      logic [RR_IW-1:0] idx;
   } rr_pick_t;

   // First set bit of valid[n-1:0] scanning upward from ptr and wrapping at n.
   // The scan runs downward so the lowest circular offset is written last and wins.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                        input logic [RR_IW-1:0]  ptr,
                                        input int                n);
      rr_pick_t r;
      int       j;
      r = '0;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (valid[j[RR_IW-1:0]]) begin
               r.found = 1'b1;
               r.idx   = j[RR_IW-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// Requester, shared-FIFO and consumer signals of the arbiter grouped as one bundle.
interface fifo_rr_arbiter_if #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 32,
   parameter int CAPACITY = 15
);
   localparam int PW = $clog2(N_REQ);
   localparam int OW = $clog2(CAPACITY + 1);

   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0][WIDTH-1:0] req_data;
   logic [N_REQ-1:0]            req_last;
   logic [N_REQ-1:0]            req_ready;
   logic                        fifo_enq;
   logic [WIDTH-1:0]            fifo_data;
   logic                        fifo_deq;
   logic                        fifo_empty;
   logic                        cons_deq;
   logic                        cons_valid;
   logic [OW-1:0]               occupancy;
   logic [PW-1:0]               grant_idx;
   logic                        locked;

   // Arbiter side
   modport slave (
      input  req_valid, req_data, req_last, fifo_empty, cons_deq,
      output req_ready, fifo_enq, fifo_data, fifo_deq, cons_valid,
             occupancy, grant_idx, locked
   );

   // Requesters, FIFO and consumer side
   modport master (
      output req_valid, req_data, req_last, fifo_empty, cons_deq,
      input  req_ready, fifo_enq, fifo_data, fifo_deq, cons_valid,
             occupancy, grant_idx, locked
   );
endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational circular priority encoder: first valid requester at or after i_ptr.
module rr_pick_comb
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [PW-1:0]    i_ptr,
   output logic             o_found,
   output logic [PW-1:0]    o_idx
);
   rr_pick_t w_pick;

   assign w_pick  = rr_pick(RR_MAX'(i_valid), RR_IW'(i_ptr), N_REQ);
   assign o_found = w_pick.found;
   assign o_idx   = PW'(w_pick.idx);
endmodule

// File: rtl/fifo_rr_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared FIFO that has no full flag;
// the occupancy count kept here is the only thing stopping overflow and underflow.
//
// state  | meaning
// IDLE   | no packet open; winner picked round-robin from rr_ptr each cycle
// LOCKED | packet open on grant_idx; only that requester may transfer
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 32,
   parameter int CAPACITY = 15
) (
   input logic               clk,
   input logic               rstn,
   fifo_rr_arbiter_if.slave  bus
);
   localparam int PW = $clog2(N_REQ);
   localparam int OW = $clog2(CAPACITY + 1);

   arb_state_t       r_state, w_state_nxt;
   logic [PW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
   logic [PW-1:0]    r_grant_idx, w_grant_nxt;
   logic [OW-1:0]    r_occ, w_occ_nxt;

   logic             w_found;
   logic [PW-1:0]    w_pick_idx;
   logic [PW-1:0]    w_sel;
   logic             w_space;
   logic             w_xfer;
   logic             w_deq;
   logic [N_REQ-1:0] w_ready;
   logic [WIDTH-1:0] w_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(N_REQ - 1)) ? '0 : p + PW'(1);
   endfunction

   rr_pick_comb #(.N_REQ(N_REQ)) u_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   // No deq bypass: a full FIFO refuses a beat even while the consumer pops.
   always_comb begin
      w_space = (r_occ < OW'(CAPACITY));
      w_sel   = (r_state == LOCKED) ? r_grant_idx : w_pick_idx;
      w_ready = '0;
      if (rstn && w_space && ((r_state == LOCKED) || w_found))
         w_ready[w_sel] = 1'b1;
      w_xfer  = |(w_ready & bus.req_valid);
      w_data  = w_xfer ? bus.req_data[w_sel] : '0;
      w_deq   = rstn && bus.cons_deq && (r_occ != '0);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_grant_nxt  = r_grant_idx;
      w_occ_nxt    = r_occ;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               w_grant_nxt = w_sel;
               if (bus.req_last[w_sel]) w_rr_ptr_nxt = ptr_inc(w_sel);
               else                     w_state_nxt  = LOCKED;
            end
         end
         LOCKED: begin
            if (w_xfer && bus.req_last[w_sel]) begin
               w_state_nxt  = IDLE;
               w_rr_ptr_nxt = ptr_inc(r_grant_idx);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      case ({w_xfer, w_deq})
         2'b10:   w_occ_nxt = r_occ + OW'(1);
         2'b01:   w_occ_nxt = r_occ - OW'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_occ       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant_idx <= w_grant_nxt;
         r_occ       <= w_occ_nxt;
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.fifo_enq   = w_xfer;
   assign bus.fifo_data  = w_data;
   assign bus.fifo_deq   = w_deq;
   assign bus.cons_valid = (r_occ != '0);
   assign bus.occupancy  = r_occ;
   assign bus.grant_idx  = r_grant_idx;
   assign bus.locked     = (r_state == LOCKED);

   // The FIFO's own empty flag must agree with the count kept here.
   a_empty_match: assert property (@(posedge clk) disable iff (!rstn)
      bus.fifo_empty == (r_occ == '0));
   a_occ_cap: assert property (@(posedge clk) disable iff (!rstn)
      r_occ <= OW'(CAPACITY));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(w_deq && (r_occ == '0)));
   a_one_ready: assert property (@(posedge clk) disable iff (!rstn)
      $onehot0(w_ready));
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Randomised and directed checks of fifo_rr_arbiter against a queue-based model.
module tb_fifo_rr_arbiter;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int CAP = 15;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fifo_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .CAPACITY(CAP)) bif ();

   fifo_rr_arbiter #(.N_REQ(N), .WIDTH(W), .CAPACITY(CAP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: occupancy, round-robin pointer, open packet, expected FIFO contents.
   int         m_occ, m_ptr, m_grant;
   bit         m_locked;
   logic [W-1:0] mq[$];
   logic [W-1:0] fq[$];

   typedef struct {
      logic [N-1:0] ready;
      logic         enq;
      logic [W-1:0] data;
      logic         deq;
      logic         last;
      int           sel;
   } exp_t;

   function automatic exp_t model_eval();
      exp_t e;
      e.ready = '0; e.enq = 1'b0; e.data = '0; e.deq = 1'b0; e.last = 1'b0; e.sel = -1;
      if (!rstn) return e;
      if (m_locked) e.sel = m_grant;
      else begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (e.sel < 0 && bif.req_valid[i]) e.sel = i;
         end
      end
      if (e.sel >= 0) begin
         if (m_occ < CAP) e.ready[e.sel] = 1'b1;
         e.enq  = e.ready[e.sel] && bif.req_valid[e.sel];
         e.last = bif.req_last[e.sel];
         if (e.enq) e.data = bif.req_data[e.sel];
      end
      e.deq = bif.cons_deq && (m_occ > 0);
      return e;
   endfunction

   always @(posedge clk or negedge rstn) begin
      exp_t e;
      logic [W-1:0] got, expd;
      if (!rstn) begin
         m_occ = 0; m_ptr = 0; m_grant = 0; m_locked = 0;
         mq.delete();
         fq.delete();
         bif.fifo_empty = 1'b1;
      end else begin
         e   = model_eval();
         got = 'x;
         if (bif.fifo_deq && fq.size() > 0) got = fq.pop_front();
         if (e.deq) begin
            expd = mq.pop_front();
            chk("pop_order", 64'(got), 64'(expd));
         end
         if (bif.fifo_enq) fq.push_back(bif.fifo_data);
         if (e.enq) begin
            mq.push_back(e.data);
            if (!m_locked) begin
               m_grant = e.sel;
               if (e.last) m_ptr = (e.sel + 1) % N;
               else        m_locked = 1;
            end else if (e.last) begin
               m_locked = 0;
               m_ptr    = (m_grant + 1) % N;
            end
         end
         m_occ = m_occ + int'(e.enq) - int'(e.deq);
         bif.fifo_empty = (fq.size() == 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = model_eval();
      chk("req_ready",  64'(bif.req_ready),  64'(e.ready));
      chk("fifo_enq",   64'(bif.fifo_enq),   64'(e.enq));
      chk("fifo_data",  64'(bif.fifo_data),  64'(e.data));
      chk("fifo_deq",   64'(bif.fifo_deq),   64'(e.deq));
      chk("cons_valid", 64'(bif.cons_valid), 64'(m_occ != 0));
      chk("occupancy",  64'(bif.occupancy),  64'(m_occ));
      chk("grant_idx",  64'(bif.grant_idx),  64'(m_grant));
      chk("locked",     64'(bif.locked),     64'(m_locked));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bif.req_valid = '1;
      bif.req_last  = '1;
      bif.cons_deq  = 1'b1;
      for (int i = 0; i < N; i++) bif.req_data[i] = W'(32'hA0 + i);
      repeat (2) @(posedge clk);
      #3;
      chk("rst_ready",  64'(bif.req_ready),  64'(0));
      chk("rst_occ",    64'(bif.occupancy),  64'(0));
      chk("rst_locked", 64'(bif.locked),     64'(0));
      chk("rst_deq",    64'(bif.fifo_deq),   64'(0));
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Fairness: four single-beat requesters, no consumer.
      bif.cons_deq = 1'b0;
      for (int c = 0; c < 15; c++) begin
         #2;
         chk("fair_data", 64'(bif.fifo_data), 64'(32'hA0 + (c % 4)));
         if (c > 0) chk("fair_grant", 64'(bif.grant_idx), 64'((c - 1) % 4));
         tick();
      end
      #2;
      chk("fair_full_occ",   64'(bif.occupancy), 64'(15));
      chk("fair_full_ready", 64'(bif.req_ready), 64'(0));

      // Drain.
      bif.req_valid = '0;
      bif.cons_deq  = 1'b1;
      repeat (15) tick();
      bif.cons_deq = 1'b0;
      #2;
      chk("drain_occ", 64'(bif.occupancy), 64'(0));

      // Burst lock: req0 three beats while req1 waits with a single beat.
      bif.req_valid   = 4'b0011;
      bif.req_last    = 4'b0010;
      bif.req_data[1] = 32'hC1;
      bif.req_data[0] = 32'hB0;
      #2;
      chk("burst_b0_ready", 64'(bif.req_ready), 64'(4'b0001));
      chk("burst_b0_lock",  64'(bif.locked),    64'(0));
      tick();
      bif.req_data[0] = 32'hB1;
      #2;
      chk("burst_b1_ready", 64'(bif.req_ready), 64'(4'b0001));
      chk("burst_b1_lock",  64'(bif.locked),    64'(1));
      tick();
      bif.req_data[0] = 32'hB2;
      bif.req_last    = 4'b0011;
      #2;
      chk("burst_b2_data",  64'(bif.fifo_data), 64'(32'hB2));
      chk("burst_b2_lock",  64'(bif.locked),    64'(1));
      tick();
      bif.req_valid = 4'b0010;
      #2;
      chk("burst_r1_ready", 64'(bif.req_ready), 64'(4'b0010));
      chk("burst_r1_data",  64'(bif.fifo_data), 64'(32'hC1));
      chk("burst_r1_lock",  64'(bif.locked),    64'(0));
      tick();

      // Full boundary with req2; occupancy is 4 here.
      bif.req_valid   = 4'b0100;
      bif.req_last    = '1;
      bif.req_data[2] = 32'hD2;
      repeat (11) tick();
      bif.cons_deq = 1'b1;
      #2;
      chk("full_occ",   64'(bif.occupancy), 64'(15));
      chk("full_enq",   64'(bif.fifo_enq),  64'(0));
      chk("full_deq",   64'(bif.fifo_deq),  64'(1));
      tick();
      bif.cons_deq = 1'b0;
      #2;
      chk("full_occ_m1", 64'(bif.occupancy), 64'(14));
      chk("full_ready2", 64'(bif.req_ready), 64'(4'b0100));
      tick();
      #2;
      chk("full_refill", 64'(bif.occupancy), 64'(15));

      // Simultaneous enq/deq holding occupancy at 5.
      bif.req_valid = '0;
      bif.cons_deq  = 1'b1;
      repeat (10) tick();
      bif.req_valid = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         bif.req_data[0] = W'(32'hE0 + k);
         #2;
         chk("steady_occ", 64'(bif.occupancy), 64'(5));
         chk("steady_enq", 64'(bif.fifo_enq),  64'(1));
         tick();
      end

      // Underflow.
      bif.req_valid = '0;
      repeat (5) tick();
      #2;
      chk("uflow_occ",   64'(bif.occupancy),  64'(0));
      chk("uflow_deq",   64'(bif.fifo_deq),   64'(0));
      chk("uflow_valid", 64'(bif.cons_valid), 64'(0));
      tick();
      bif.cons_deq = 1'b0;
      #2;
      chk("uflow_occ2",  64'(bif.occupancy),  64'(0));

      // Reset while req3 holds a packet open.
      bif.req_valid   = 4'b1000;
      bif.req_last    = 4'b0000;
      bif.req_data[3] = 32'hF3;
      tick();
      #2;
      chk("mid_locked",  64'(bif.locked),    64'(1));
      chk("mid_grant",   64'(bif.grant_idx), 64'(3));
      rstn          = 1'b0;
      bif.req_valid = '0;
      #1;
      chk("mid_rst_lock", 64'(bif.locked),    64'(0));
      chk("mid_rst_occ",  64'(bif.occupancy), 64'(0));
      tick();
      rstn            = 1'b1;
      bif.req_valid   = 4'b1010;
      bif.req_last    = 4'b1010;
      bif.req_data[1] = 32'h11;
      bif.req_data[3] = 32'h33;
      #2;
      chk("post_rst_ready", 64'(bif.req_ready), 64'(4'b0010));
      chk("post_rst_data",  64'(bif.fifo_data), 64'(32'h11));
      tick();
      #2;
      chk("post_rst_next",  64'(bif.req_ready), 64'(4'b1000));
      tick();

      // Randomised traffic with shifting consumer pressure.
      for (int seg = 0; seg < 10; seg++) begin
         int p;
         p = (seg % 3 == 0) ? 15 : ((seg % 3 == 1) ? 50 : 85);
         repeat (300) begin
            bif.req_valid = N'($urandom);
            bif.req_last  = N'($urandom & $urandom);
            for (int i = 0; i < N; i++) bif.req_data[i] = $urandom;
            bif.cons_deq  = (int'($urandom_range(0, 99)) < p);
            tick();
         end
      end
      bif.req_valid = '0;
      bif.cons_deq  = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Shares one downstream FIFO instance among N requesters; the FIFO has only enq/data_in/deq/data_out/empty and no full output.
- Round-robin arbitration at packet granularity; a multi-beat packet holds the grant until its last beat.
- Keeps its own occupancy count, so the FIFO is never enqueued beyond CAPACITY; also gates consumer dequeues.
- Sits between the bus-master request ports and the shared FIFO on the system bus.

Parameters:
- N_REQ, 4: number of requesters, minimum 2.
- WIDTH, 32: data beat width; must equal the FIFO WIDTH.
- CAPACITY, 15: maximum entries the controller allows in the FIFO; must be at most FIFO DEPTH-1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ x WIDTH  per-requester beat data (packed)
- req_last  in  N_REQ  beat is the last of its packet
- req_ready  out  N_REQ  per-requester beat accepted
- fifo_enq  out  1  to FIFO enq
- fifo_data  out  WIDTH  to FIFO data_in
- fifo_deq  out  1  to FIFO deq
- fifo_empty  in  1  from FIFO empty
- cons_deq  in  1  consumer pop request
- cons_valid  out  1  FIFO holds data, equal to occupancy != 0
- occupancy  out  clog2(CAPACITY+1)  current entry count
- grant_idx  out  clog2(N_REQ)  current/last granted requester
- locked  out  1  packet in progress

Behaviour:
- Reset, asynchronous on rstn low:
  - state=IDLE, occupancy=0, rr_ptr=0, grant_idx=0, locked=0.
  - All outputs 0.
- Space and transfers:
  - space = (occupancy < CAPACITY). There is no same-cycle deq bypass, so a full FIFO accepts nothing even if deq happens that cycle.
  - A transfer occurs for requester i when req_valid[i] and req_ready[i] are both high.
  - At most one req_ready bit is high per cycle.
- State IDLE:
  - Select winner = first i with req_valid[i], scanning circularly from rr_ptr.
  - req_ready[winner] = space; the path from req_valid to req_ready is combinational, so accept latency is 0 cycles.
  - On transfer with req_last=1: stay IDLE; rr_ptr <= winner+1 (mod N_REQ); grant_idx <= winner.
  - On transfer with req_last=0: go to LOCKED; grant_idx <= winner; locked <= 1.
  - No valid requester or !space: no transfer and rr_ptr unchanged.
- State LOCKED:
  - Only grant_idx is eligible; req_ready[grant_idx] = space.
  - Other requesters' valid bits are ignored.
  - Transfer with req_last=1: go to IDLE; locked <= 0; rr_ptr <= grant_idx+1.
  - Requester deasserting valid mid-packet: remain LOCKED with no timeout.
- FIFO enqueue side:
  - fifo_enq = any transfer.
  - fifo_data = req_data of the transferring requester, else 0.
- FIFO dequeue side:
  - fifo_deq = cons_deq && occupancy != 0.
  - A cons_deq while occupancy == 0 is ignored.
  - An inconsistency between fifo_empty and (occupancy == 0) is a simulation assertion failure.
- Occupancy update, registered:
  - +1 on enq only; -1 on deq only; unchanged when both or neither happen.
  - Never exceeds CAPACITY and never underflows (both are assertions).
- rr_ptr wraps from N_REQ-1 to 0.
- Simultaneous enq and deq at occupancy == CAPACITY: enq is blocked and deq is taken; next cycle occupancy = CAPACITY-1.
- Reset mid-packet: returns to IDLE. A partial packet already in the FIFO is the consumer's responsibility. A FIFO reset must accompany any controller reset.

Decomposition:
- Package fifo_arb_pkg:
  - typedef arb_state_t {IDLE, LOCKED}
  - function rr_pick(valid, ptr) returning {found, idx}
- Sub-module rr_pick_comb (combinational circular priority encoder, parameter N_REQ) for reuse by other bus arbiters.
- State, occupancy counter and muxing stay in the top module.

Test Plan (N_REQ=4, WIDTH=32, CAPACITY=15):
- Fairness: all four valid with single-beat packets, data 0xA0+i, no deq → FIFO receives A0, A1, A2, A3, A0, …; grant_idx cycles 0,1,2,3; occupancy reaches 15 after 15 cycles, then all req_ready are 0.
- Burst lock: req0 sends 3 beats (last on the 3rd) while req1 is valid throughout → beats 0,0,0 enqueued, then req1; locked=1 for 2 cycles.
- Full boundary: occupancy=15, cons_deq=1 and req2 valid in the same cycle → no enq, fifo_deq=1, occupancy=14; the next cycle req2 is accepted and occupancy=15.
- Simultaneous enq/deq at occupancy=5 for 10 cycles → occupancy stays 5 and the FIFO drains in order.
- Underflow: cons_deq=1 with occupancy=0 → fifo_deq=0, cons_valid=0, occupancy stays 0.
- Mid-packet reset: rstn low for 1 cycle while LOCKED on req3 → locked=0, occupancy=0, rr_ptr=0; the next arbitration with req1 and req3 valid grants req1.
